// File: rtl/apb_cfg_arbiter.sv
// Two-requester round-robin arbiter driving a fixed-length APB master.
// Ports: pclk/prst, req0_*/req1_* requests, rsp0_*/rsp1_* completions, APB bus, busy.
module apb_cfg_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   cur_id;
  logic   gnt0;
  logic   gnt1;

  // last_gnt=1 means requester 1 won the previous grant,
  // so requester 0 takes the next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !prst) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          gnt0 = last_gnt;
          gnt1 = !last_gnt;
        end
        (req0_valid && !req1_valid): gnt0 = 1'b1;
        (!req0_valid && req1_valid): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      cur_id     <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state    <= SETUP;
            psel     <= 1'b1;
            penable  <= 1'b0;
            busy     <= 1'b1;
            cur_id   <= gnt1;
            last_gnt <= gnt1;
            pwrite   <= gnt1 ? req1_write : req0_write;
            paddr    <= gnt1 ? req1_addr : req0_addr;
            pwdata   <= gnt1 ? req1_wdata : req0_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          // prdata is captured on the edge that closes ACCESS
          if (cur_id) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= pwrite ? '0 : prdata;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= pwrite ? '0 : prdata;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_cfg_arbiter.md
APB_CFG_ARBITER -- requirements
Module: apb_cfg_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 12, APB address width; DATA_W, 32, APB data width.
REQ-002 Port pclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 Port prst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 Ports reqN_valid  in  1, reqN_write  in  1, reqN_addr  in  ADDR_W, reqN_wdata  in  DATA_W (N=0,1) SHALL carry requester N's transfer request.
REQ-005 Port reqN_ready  out  1 (N=0,1) SHALL be the acceptance strobe for requester N.
REQ-006 Ports rspN_valid  out  1, rspN_rdata  out  DATA_W (N=0,1) SHALL be the completion pulse and read data for requester N.
REQ-007 Ports psel, penable, pwrite  out  1; paddr  out  ADDR_W; pwdata  out  DATA_W SHALL form the APB master bus.
REQ-008 Port prdata  in  DATA_W SHALL be APB read data; the slave has no pready, so every transfer is fixed-length.
REQ-009 Port busy  out  1 SHALL be high whenever the FSM is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, SETUP, ACCESS; transitions: IDLE->SETUP on grant; SETUP->ACCESS always; ACCESS->IDLE always.
REQ-011 IDLE: psel=0, penable=0. SETUP: psel=1, penable=0. ACCESS: psel=1, penable=1.
REQ-012 Grant SHALL occur only in IDLE: if exactly one reqN_valid is high, grant N. If both are high, grant the requester not granted last (round-robin).
REQ-013 reqN_ready SHALL be combinational, high only in IDLE in the cycle requester N is granted; at most one ready is high per cycle.
REQ-014 On grant, the block SHALL latch write, addr, wdata and the requester id into registers driving pwrite, paddr, pwdata.
REQ-015 pwrite, paddr and pwdata SHALL remain stable from SETUP through ACCESS, and SHALL hold their last values in IDLE.
REQ-016 Requesters SHALL hold request fields stable while valid && !ready; a request deasserted before ready is dropped without error.
REQ-017 prdata SHALL be sampled on the clock edge ending ACCESS.
REQ-018 Latency: grant in cycle T -> SETUP T+1 -> ACCESS T+2 -> rspN_valid high for exactly one cycle at T+3. Throughput is one transfer per 3 cycles.
REQ-019 rspN_valid SHALL pulse for writes and reads alike; rspN_rdata SHALL be the sampled prdata for reads and 0 for writes.
REQ-020 rspN_rdata SHALL hold its value until the next rspN_valid for the same N.
REQ-021 rspN_valid at T+3 and a new grant/reqM_ready in the same IDLE cycle SHALL both be permitted.
REQ-022 prdata SHALL be passed through unmodified, including 32'hDEADBEEF for unmapped addresses.
REQ-023 A continuously valid requester SHALL be granted within at most 2 consecutive grants; no starvation.
REQ-024 reqN_* inputs SHALL be ignored outside IDLE.

Reset
REQ-025 While prst=1 at a clock edge, the FSM SHALL go to IDLE with the following outputs 0: psel, penable, pwrite, paddr, pwdata, busy, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata. The round-robin last-grant SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-026 reqN_ready SHALL be 0 while prst=1.
REQ-027 Reset asserted in SETUP or ACCESS SHALL abort the transfer: psel/penable are 0 after the edge, and no rspN_valid is ever issued for it.

Verification
REQ-028 Write: req0 write, addr 0x308, wdata 0x12340010 at T -> req0_ready=1 at T; T+1 psel=1 penable=0 paddr=0x308; T+2 penable=1 pwrite=1 pwdata=0x12340010; T+3 rsp0_valid=1, rsp0_rdata=0.
REQ-029 Read: req1 read, addr 0x300, with the slave model driving prdata=0xA5A50001 in ACCESS -> rsp1_valid=1 at T+3 with rsp1_rdata=0xA5A50001; the value is held afterwards.
REQ-030 Tie after reset: req0 and req1 both held valid -> grants alternate 0,1,0,1 every 3 cycles; the first rsp0_valid comes 3 cycles before the first rsp1_valid.
REQ-031 Back-to-back: req0 continuously valid, req1 asserted mid-transfer -> req1 is granted at the next IDLE; rsp0_valid and req1_ready coincide in that cycle.
REQ-032 Abort: prst pulsed for 1 cycle during ACCESS of a read -> next cycle psel=0, penable=0, busy=0; no rsp pulse; the next request completes normally.
REQ-033 Unmapped read: addr 0xFFC with prdata=0xDEADBEEF -> rsp0_rdata=0xDEADBEEF.
